// File: rtl/adc_buffer_reader.sv
// adc_buffer_reader: read-side controller for the ADC sample buffer. Walks a
// wrap-around address range of the buffer's synchronous read port, absorbs
// its one-cycle read latency and streams the samples out in address order
// on a valid/ready port with full backpressure.
module adc_buffer_reader #(
   parameter int DATA_WIDTH  = 12,
   parameter int BUFFER_SIZE = 4096,
   parameter int ADDR_WIDTH  = 12,
   parameter int FIFO_DEPTH  = 4
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] start_addr,
   input  logic [ADDR_WIDTH:0]   length,
   input  logic                  abort,
   output logic [ADDR_WIDTH-1:0] read_addr,
   input  logic [DATA_WIDTH-1:0] read_data,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic                  m_last,
   output logic                  busy,
   output logic                  done
);

   localparam int LEN_W = ADDR_WIDTH + 1;
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(BUFFER_SIZE);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   state_t                state, state_next;
   logic [ADDR_WIDTH-1:0] addr_cnt;
   logic [LEN_W-1:0]      issue_rem;
   logic [LEN_W-1:0]      out_rem;
   logic                  rd_pending;  // buffer samples read_addr at the coming edge
   logic                  rd_valid;    // read_data holds a sample to capture at the coming edge
   logic [DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]      wr_ptr, rd_ptr;
   logic [CNT_W-1:0]      fifo_count;

   logic [LEN_W-1:0]      len_clamped;
   logic [CNT_W-1:0]      occupancy;
   logic                  kill, accept, issue, pop, final_pop;
   logic [ADDR_WIDTH-1:0] issue_addr;
   logic [LEN_W-1:0]      issue_base;

   // Reads in flight count against the FIFO so a stalled output never overflows it.
   assign len_clamped = (length > MAX_LEN) ? MAX_LEN : length;
   assign occupancy   = fifo_count + CNT_W'(rd_pending) + CNT_W'(rd_valid);
   assign kill        = abort && (state != IDLE);
   assign m_valid     = (fifo_count != '0);
   assign pop         = m_valid && m_ready;
   assign m_data      = m_valid ? fifo_mem[rd_ptr] : '0;
   assign m_last      = m_valid && (out_rem == LEN_W'(1));
   assign busy        = (state != IDLE);

   // Next-state, read-issue and completion decisions.
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can infer a latch.
      state_next = state;
      accept     = 1'b0;
      issue      = 1'b0;
      final_pop  = 1'b0;
      issue_addr = addr_cnt;
      issue_base = issue_rem;
      unique case (state)
         IDLE: begin
            issue_addr = start_addr;
            if (start && !abort) begin
               accept     = 1'b1;
               issue_base = len_clamped;
               if (len_clamped != '0) begin
                  issue      = 1'b1;
                  state_next = RUN;
               end
            end
         end
         RUN: begin
            if (issue_rem == '0) state_next = DRAIN;
            else                 issue = (occupancy < CNT_W'(FIFO_DEPTH));
            final_pop = pop && m_last;
         end
         DRAIN:   final_pop = pop && m_last;
         default: state_next = IDLE;
      endcase
      if (final_pop) state_next = IDLE;
      if (kill) begin
         state_next = IDLE;
         issue      = 1'b0;
         final_pop  = 1'b0;
      end
   end

   // State register.
   always_ff @(posedge clock) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   // Address and length counters, read pipeline tracking and the done pulse.
   always_ff @(posedge clock) begin
      if (reset) begin
         addr_cnt   <= '0;
         read_addr  <= '0;
         issue_rem  <= '0;
         out_rem    <= '0;
         rd_pending <= 1'b0;
         rd_valid   <= 1'b0;
         done       <= 1'b0;
      end else begin
         issue_rem  <= issue_base - LEN_W'(issue);
         rd_pending <= issue;
         rd_valid   <= rd_pending && !kill;
         done       <= final_pop || (accept && (len_clamped == '0));
         if (issue) begin
            read_addr <= issue_addr;
            addr_cnt  <= issue_addr + ADDR_WIDTH'(1);
         end
         if (accept)   out_rem <= len_clamped;
         else if (pop) out_rem <= out_rem - LEN_W'(1);
      end
   end

   // FIFO pointers and fill level; an abort flushes the FIFO.
   always_ff @(posedge clock) begin
      if (reset || kill) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (rd_valid) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)      rd_ptr <= rd_ptr + PTR_W'(1);
         fifo_count <= fifo_count + CNT_W'(rd_valid) - CNT_W'(pop);
      end
   end

   // FIFO storage: captures read_data one cycle after each issued read.
   always_ff @(posedge clock) begin
      // NOTE: the storage array has no reset; m_data is masked while the FIFO is empty instead.
      if (rd_valid) fifo_mem[wr_ptr] <= read_data;
   end

endmodule

// File: tb/tb_adc_buffer_reader.sv
// Testbench for adc_buffer_reader: buffer memory model, scoreboard queue filled
// from the address/length rules at each start, and a negedge monitor that
// checks every handshake, stall stability, busy and done.
module tb_adc_buffer_reader;

   localparam int DW = 12;
   localparam int AW = 12;
   localparam int BS = 4096;
   localparam int FD = 4;

   logic          clock = 1'b0;
   logic          reset, start, abort, m_ready;
   logic [AW-1:0] start_addr, read_addr;
   logic [AW:0]   length;
   logic [DW-1:0] read_data, m_data;
   logic          m_valid, m_last, busy, done;

   typedef struct packed {
      logic [DW-1:0] data;
      logic          last;
   } beat_t;

   beat_t         exp_q[$];
   beat_t         cur;
   logic [DW-1:0] mem [BS];
   int            compared = 0;
   int            mismatched = 0;
   int            beats = 0;
   bit            model_busy = 1'b0, busy_clear = 1'b0, done_due = 1'b0, zl_flag = 1'b0;
   bit            exp_done;
   bit            prev_stalled = 1'b0;
   logic [DW-1:0] prev_data;
   logic          prev_last;
   int            base, k, a, n, d;

   adc_buffer_reader #(
      .DATA_WIDTH(DW), .BUFFER_SIZE(BS), .ADDR_WIDTH(AW), .FIFO_DEPTH(FD)
   ) dut (
      .clock(clock), .reset(reset), .start(start), .start_addr(start_addr),
      .length(length), .abort(abort), .read_addr(read_addr), .read_data(read_data),
      .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
      .busy(busy), .done(done)
   );

   always #5 clock = ~clock;

   // Buffer read port: one-cycle synchronous read latency.
   always @(posedge clock) read_data <= mem[read_addr];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got 0x%0h, want 0x%0h at t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   // Drives one start pulse; the expected stream is derived from the buffer contents.
   task automatic issue_start(input logic [AW-1:0] addr, input int len);
      int eff;
      eff = (len > BS) ? BS : len;
      for (int i = 0; i < eff; i++) begin
         beat_t b;
         b.data = mem[(int'(addr) + i) % BS];
         b.last = (i == eff - 1);
         exp_q.push_back(b);
      end
      start_addr = addr;
      length     = (AW+1)'(len);
      start      = 1'b1;
      cyc();
      start = 1'b0;
      if (eff == 0) zl_flag = 1'b1;
      else          model_busy = 1'b1;
   endtask

   task automatic wait_idle(input int max_cycles, input bit rand_ready);
      int c;
      c = 0;
      while ((exp_q.size() != 0 || busy) && c < max_cycles) begin
         if (rand_ready) m_ready = ($urandom_range(0, 3) != 0);
         cyc();
         c++;
      end
      if (exp_q.size() != 0 || busy) begin
         compared++;
         mismatched++;
         $display("FAIL wait_idle: readout unfinished after %0d cycles, %0d beats left", max_cycles, exp_q.size());
      end
   endtask

   task automatic do_abort();
      abort = 1'b1;
      cyc();
      abort = 1'b0;
      exp_q.delete();
      model_busy   = 1'b0;
      busy_clear   = 1'b0;
      done_due     = 1'b0;
      prev_stalled = 1'b0;
      check("abort_valid", 32'(m_valid), 32'd0);
      check("abort_busy", 32'(busy), 32'd0);
   endtask

   // Monitor: samples between active edges and compares against the scoreboard.
   always @(negedge clock) begin
      if (reset) begin
         prev_stalled = 1'b0;
      end else begin
         exp_done = done_due | zl_flag;
         done_due = 1'b0;
         zl_flag  = 1'b0;
         if (busy_clear) begin
            model_busy = 1'b0;
            busy_clear = 1'b0;
         end
         check("done", 32'(done), 32'(exp_done));
         check("busy", 32'(busy), 32'(model_busy));
         if (prev_stalled) begin
            check("stall_valid", 32'(m_valid), 32'd1);
            check("stall_data", 32'(m_data), 32'(prev_data));
            check("stall_last", 32'(m_last), 32'(prev_last));
         end
         if (exp_q.size() == 0) begin
            check("idle_valid", 32'(m_valid), 32'd0);
         end else if (m_valid && m_ready) begin
            cur = exp_q.pop_front();
            check("beat_data", 32'(m_data), 32'(cur.data));
            check("beat_last", 32'(m_last), 32'(cur.last));
            beats++;
            if (cur.last) begin
               done_due   = 1'b1;
               busy_clear = 1'b1;
            end
         end
         prev_stalled = m_valid && !m_ready;
         prev_data    = m_data;
         prev_last    = m_last;
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin
      for (int i = 0; i < BS; i++) mem[i] = DW'(i);
      reset = 1'b1; start = 1'b1; abort = 1'b1; m_ready = 1'b1;
      start_addr = 12'h020; length = 13'd4;
      repeat (3) cyc();
      check("rst_read_addr", 32'(read_addr), 32'd0);
      check("rst_m_data", 32'(m_data), 32'd0);
      check("rst_m_valid", 32'(m_valid), 32'd0);
      check("rst_m_last", 32'(m_last), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      reset = 1'b0; start = 1'b0; abort = 1'b0;
      for (int i = 0; i < 5; i++) begin
         cyc();
         check("post_rst_addr", 32'(read_addr), 32'd0);
         check("post_rst_valid", 32'(m_valid), 32'd0);
      end

      // Basic readout: latency 3, consecutive beats, done one cycle after last.
      issue_start(12'h010, 8);
      check("lat_addr", 32'(read_addr), 32'h010);
      check("lat_valid_1", 32'(m_valid), 32'd0);
      cyc();
      check("lat_valid_2", 32'(m_valid), 32'd0);
      cyc();
      check("lat_valid_3", 32'(m_valid), 32'd1);
      check("first_data", 32'(m_data), 32'h010);
      for (int i = 1; i < 8; i++) begin
         cyc();
         check("stream_valid", 32'(m_valid), 32'd1);
         check("stream_data", 32'(m_data), 32'(16 + i));
      end
      check("stream_last", 32'(m_last), 32'd1);
      cyc();
      check("done_pulse", 32'(done), 32'd1);
      check("busy_after", 32'(busy), 32'd0);
      wait_idle(20, 1'b0);

      // Address wrap.
      issue_start(12'hFFE, 4);
      check("wrap_addr0", 32'(read_addr), 32'hFFE);
      cyc();
      check("wrap_addr1", 32'(read_addr), 32'hFFF);
      cyc();
      check("wrap_addr2", 32'(read_addr), 32'h000);
      cyc();
      check("wrap_addr3", 32'(read_addr), 32'h001);
      wait_idle(30, 1'b0);

      // Backpressure: issue stalls once FIFO plus in-flight reads fill up.
      m_ready = 1'b0;
      issue_start(12'h200, 32);
      for (int i = 0; i < 10; i++) begin
         check("bp_addr", 32'(read_addr), 32'(12'h200 + ((i < 3) ? i : 3)));
         if (i >= 2) check("bp_valid", 32'(m_valid), 32'd1);
         if (i < 9) cyc();
      end
      wait_idle(400, 1'b1);

      // Abort after the third handshake; a start in the abort cycle is ignored.
      m_ready = 1'b1;
      base = beats;
      issue_start(12'h300, 16);
      k = 0;
      while (beats < base + 3 && k < 50) begin
         cyc();
         k++;
      end
      if (beats < base + 3) begin
         compared++;
         mismatched++;
         $display("FAIL abort_wait: only %0d beats seen", beats - base);
      end
      start = 1'b1; start_addr = 12'h500; length = 13'd3;
      do_abort();
      start = 1'b0;
      cyc();
      check("abort_no_done", 32'(done), 32'd0);
      check("abort_idle_valid", 32'(m_valid), 32'd0);
      repeat (2) cyc();
      issue_start(12'h100, 2);
      wait_idle(20, 1'b0);

      // Zero length: done pulse only.
      issue_start(12'h050, 0);
      check("zero_done", 32'(done), 32'd1);
      check("zero_busy", 32'(busy), 32'd0);
      for (int i = 0; i < 4; i++) begin
         cyc();
         check("zero_valid", 32'(m_valid), 32'd0);
         check("zero_done_once", 32'(done), 32'd0);
      end

      // Start while busy is ignored.
      issue_start(12'h400, 6);
      repeat (2) cyc();
      start = 1'b1; start_addr = 12'h777; length = 13'd9;
      cyc();
      start = 1'b0;
      wait_idle(100, 1'b1);

      // Full buffer and an over-long request clamped to the buffer size.
      m_ready = 1'b1;
      issue_start(12'h123, 4096);
      wait_idle(4300, 1'b0);
      issue_start(12'h800, 5000);
      wait_idle(4300, 1'b0);

      // Randomized readouts over random buffer contents, with occasional aborts.
      for (int i = 0; i < BS; i++) mem[i] = DW'($urandom);
      for (int t = 0; t < 24; t++) begin
         a = $urandom_range(0, BS - 1);
         n = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 48);
         if (t == 5) a = BS - 3;
         issue_start(AW'(a), n);
         if ($urandom_range(0, 3) == 0) begin
            d = $urandom_range(0, 20);
            for (int j = 0; j < d && busy; j++) begin
               m_ready = ($urandom_range(0, 3) != 0);
               cyc();
            end
            if (busy) do_abort();
         end
         wait_idle(600, 1'b1);
         repeat ($urandom_range(0, 2)) cyc();
      end

      repeat (5) cyc();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
